credit_tx: RTL and testbench

Credit-based transmitter: the sending end of a link whose far end is a fixed-depth receive FIFO. It accepts elements on a valid/ready stream and forwards each one as a single-cycle `tx_valid_o` beat with no backpressure. A local credit counter, initialised to the remote FIFO depth, throttles the stream, and the receiver returns one credit per element it pops. It sits in front of any `fifo` instance reached over a registered or long-wire path where a combinational ready cannot be routed back.

---
 rtl/credit_tx.sv | 96 +++++++++
 tb/tb_credit_tx.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/credit_tx.sv
// Credit-based transmitter: forwards a valid/ready stream as unstalled tx beats, throttled by remote FIFO credits.
// Optional sticky overflow detection is enabled with `define CREDIT_TX_ERR_CHECK_EN.
module credit_tx #(
  parameter int ElemWidth = 8,
  parameter int Credits   = 8,
  parameter int CntWidth  = $clog2(Credits + 1)
) (
  input  logic                 clk_i,
  input  logic                 srst_i,
  input  logic [ElemWidth-1:0] elem_in_i,
  input  logic                 elem_in_valid_i,
  output logic                 elem_in_ready_o,
  output logic [ElemWidth-1:0] tx_data_o,
  output logic                 tx_valid_o,
  input  logic                 credit_return_i,
  input  logic                 drain_i,
  output logic                 drain_done_o,
  output logic [CntWidth-1:0]  credit_count_o,
  output logic                 credit_err_o
);

  typedef enum logic [1:0] {
    INIT,
    RUN,
    DRAIN
  } state_t;

  localparam logic [CntWidth-1:0] FullCount = CntWidth'(Credits);
  localparam logic [CntWidth:0]   FullWide  = (CntWidth + 1)'(Credits);

  state_t              state, state_next;
  logic [CntWidth-1:0] count, count_next;
  logic [CntWidth:0]   count_sum;
  logic                handshake;
  logic                overflow;

  always_comb begin
    state_next      = state;
    elem_in_ready_o = 1'b0;
    drain_done_o    = 1'b0;
    case (state)
      INIT: state_next = RUN;
      RUN: begin
        elem_in_ready_o = (count != '0);
        if (drain_i) state_next = DRAIN;
      end
      DRAIN: begin
        drain_done_o = (count == FullCount);
        if (!drain_i) state_next = RUN;
      end
      default: state_next = INIT;
    endcase
  end

  // A handshake requires a nonzero count, so the sum never underflows.
  always_comb begin
    handshake  = elem_in_valid_i & elem_in_ready_o;
    count_sum  = {1'b0, count} - (CntWidth + 1)'(handshake)
               + (CntWidth + 1)'(credit_return_i);
    overflow   = (count_sum > FullWide);
    count_next = overflow ? FullCount : count_sum[CntWidth-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state      <= INIT;
      count      <= FullCount;
      tx_valid_o <= 1'b0;
      tx_data_o  <= '0;
    end else begin
      state      <= state_next;
      count      <= count_next;
      tx_valid_o <= handshake;
      if (handshake) tx_data_o <= elem_in_i;
    end
  end

  assign credit_count_o = count;

`ifdef CREDIT_TX_ERR_CHECK_EN
  logic err;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      err <= 1'b0;
    end else if (overflow) begin
      err <= 1'b1;
    end
  end

  assign credit_err_o = err;
`else
  assign credit_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_credit_tx.sv
// Self-checking bench for credit_tx: directed vector table for the multi-cycle corners, then random traffic against a credit-ledger model.
module tb_credit_tx;

  localparam int EW = 8;
  localparam int CR = 8;
  localparam int CW = $clog2(CR + 1);

  logic          clk = 1'b0;
  logic          srst;
  logic [EW-1:0] elem_in;
  logic          elem_in_valid;
  logic          elem_in_ready;
  logic [EW-1:0] tx_data;
  logic          tx_valid;
  logic          credit_return;
  logic          drain;
  logic          drain_done;
  logic [CW-1:0] credit_count;
  logic          credit_err;

  int errors = 0;
  int checks = 0;

`ifdef CREDIT_TX_ERR_CHECK_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  credit_tx #(
    .ElemWidth(EW),
    .Credits  (CR)
  ) dut (
    .clk_i          (clk),
    .srst_i         (srst),
    .elem_in_i      (elem_in),
    .elem_in_valid_i(elem_in_valid),
    .elem_in_ready_o(elem_in_ready),
    .tx_data_o      (tx_data),
    .tx_valid_o     (tx_valid),
    .credit_return_i(credit_return),
    .drain_i        (drain),
    .drain_done_o   (drain_done),
    .credit_count_o (credit_count),
    .credit_err_o   (credit_err)
  );

  always #5 clk = ~clk;

  // Inputs applied before an edge, expected outputs observed just after it.
  typedef struct {
    bit       rst;
    bit       valid;
    bit [7:0] data;
    bit       ret;
    bit       drn;
    bit       e_ready;
    bit       e_txv;
    bit [7:0] e_txd;
    int       e_cnt;
    bit       e_done;
    bit       e_err_en;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit rst, input bit valid, input bit [7:0] data, input bit ret,
                     input bit drn, input bit e_ready, input bit e_txv, input bit [7:0] e_txd,
                     input int e_cnt, input bit e_done, input bit e_err_en);
    vec_t v;
    v = '{rst, valid, data, ret, drn, e_ready, e_txv, e_txd, e_cnt, e_done, e_err_en};
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int step, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, step, act, exp);
    end
  endtask

  task automatic drive(input bit rst, input bit valid, input bit [7:0] data, input bit ret,
                       input bit drn);
    srst          = rst;
    elem_in_valid = valid;
    elem_in       = data;
    credit_return = ret;
    drain         = drn;
    @(posedge clk);
    #1;
  endtask

  // Reference ledger: credits held locally, link mode, last beat sent.
  int       m_credits;
  int       m_mode;  // 0 = just out of reset, 1 = streaming, 2 = draining
  bit       m_txv;
  bit [7:0] m_txd;
  bit       m_err;

  task automatic model_edge(input bit rst, input bit valid, input bit [7:0] data, input bit ret,
                            input bit drn);
    bit can_take;
    bit took;
    int want;
    if (rst) begin
      m_credits = CR;
      m_mode    = 0;
      m_txv     = 0;
      m_txd     = 0;
      m_err     = 0;
      return;
    end
    can_take = (m_mode == 1) && (m_credits > 0);
    took     = valid && can_take;
    want     = m_credits - (took ? 1 : 0) + (ret ? 1 : 0);
    if (want > CR) begin
      if (ErrEn) m_err = 1;
      want = CR;
    end
    m_credits = want;
    m_txv     = took;
    if (took) m_txd = data;
    if (m_mode == 0) m_mode = 1;
    else if (m_mode == 1 && drn) m_mode = 2;
    else if (m_mode == 2 && !drn) m_mode = 1;
  endtask

  initial begin
    srst = 1; elem_in_valid = 0; elem_in = '0; credit_return = 0; drain = 0;

    //   rst v  data   ret drn  rdy txv txd   cnt done err
    add(1, 1, 8'h10, 0, 0,   0, 0, 8'h00, 8, 0, 0);  // reset held, valid high
    add(0, 1, 8'h10, 0, 0,   1, 0, 8'h00, 8, 0, 0);  // INIT cycle: no handshake
    for (int i = 0; i < 8; i++)
      add(0, 1, 8'(8'h10 + i), 0, 0, (i != 7), 1, 8'(8'h10 + i), 7 - i, 0, 0);
    add(0, 1, 8'h18, 0, 0,   0, 0, 8'h17, 0, 0, 0);  // stalled at zero credits
    add(0, 1, 8'h18, 1, 0,   1, 0, 8'h17, 1, 0, 0);  // return at 0 -> 1
    add(0, 1, 8'h18, 0, 0,   0, 1, 8'h18, 0, 0, 0);  // returned credit consumed
    add(0, 0, 8'h00, 1, 0,   1, 0, 8'h18, 1, 0, 0);
    add(0, 0, 8'h00, 1, 0,   1, 0, 8'h18, 2, 0, 0);
    add(0, 0, 8'h00, 1, 0,   1, 0, 8'h18, 3, 0, 0);
    add(0, 1, 8'h19, 1, 0,   1, 1, 8'h19, 3, 0, 0);  // handshake + return at 3
    add(0, 0, 8'h00, 0, 0,   1, 0, 8'h19, 3, 0, 0);
    add(0, 0, 8'h00, 0, 1,   0, 0, 8'h19, 3, 0, 0);  // drain with 5 outstanding
    add(0, 1, 8'h1A, 0, 1,   0, 0, 8'h19, 3, 0, 0);  // no acceptance while draining
    for (int i = 0; i < 4; i++)
      add(0, 0, 8'h00, 1, 1, 0, 0, 8'h19, 4 + i, 0, 0);
    add(0, 0, 8'h00, 1, 1,   0, 0, 8'h19, 8, 1, 0);  // 5th return: drain done
    add(0, 0, 8'h00, 0, 0,   1, 0, 8'h19, 8, 0, 0);  // back to RUN
    add(0, 0, 8'h00, 1, 0,   1, 0, 8'h19, 8, 0, 1);  // overflowing return
    add(0, 0, 8'h00, 0, 0,   1, 0, 8'h19, 8, 0, 1);  // error is sticky
    for (int i = 0; i < 6; i++)
      add(0, 1, 8'(8'h20 + i), 0, 0, 1, 1, 8'(8'h20 + i), 7 - i, 0, 1);
    add(1, 1, 8'h26, 0, 0,   0, 0, 8'h00, 8, 0, 0);  // mid-op reset at count 2

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].valid, vecs[i].data, vecs[i].ret, vecs[i].drn);
      chk("ready", i, int'(elem_in_ready), int'(vecs[i].e_ready));
      chk("tx_valid", i, int'(tx_valid), int'(vecs[i].e_txv));
      chk("tx_data", i, int'(tx_data), int'(vecs[i].e_txd));
      chk("count", i, int'(credit_count), vecs[i].e_cnt);
      chk("drain_done", i, int'(drain_done), int'(vecs[i].e_done));
      chk("credit_err", i, int'(credit_err), int'(vecs[i].e_err_en & ErrEn));
    end

    // Random traffic; drain is a sticky level that flips occasionally.
    begin
      bit       r_rst, r_v, r_ret, r_drn;
      bit [7:0] r_d;
      r_drn = 0;
      model_edge(1, 0, 0, 0, 0);
      drive(1, 0, 8'h00, 0, 0);
      for (int n = 0; n < 3000; n++) begin
        r_rst = ($urandom_range(0, 299) == 0);
        r_v   = ($urandom_range(0, 3) != 0);
        r_ret = ($urandom_range(0, 9) < 4);
        if ($urandom_range(0, 39) == 0) r_drn = ~r_drn;
        r_d   = 8'($urandom);
        model_edge(r_rst, r_v, r_d, r_ret, r_drn);
        drive(r_rst, r_v, r_d, r_ret, r_drn);
        chk("rnd_ready", n, int'(elem_in_ready), int'(m_mode == 1 && m_credits > 0));
        chk("rnd_tx_valid", n, int'(tx_valid), int'(m_txv));
        chk("rnd_tx_data", n, int'(tx_data), int'(m_txd));
        chk("rnd_count", n, int'(credit_count), m_credits);
        chk("rnd_drain_done", n, int'(drain_done), int'(m_mode == 2 && m_credits == CR));
        chk("rnd_credit_err", n, int'(credit_err), int'(m_err));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
